// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// pipe_hazard_ctrl_pkg: ISA opcodes, branch condition codes and flag indices shared by the hazard block.
// Rev 1.0
package pipe_hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SRA  = 4'd6,
    OP_RL   = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9,
    OP_LHB  = 4'd10,
    OP_LLB  = 4'd11,
    OP_B    = 4'd12,
    OP_JAL  = 4'd13,
    OP_JR   = 4'd14,
    OP_EXEC = 4'd15
  } opcode_e;

  typedef enum logic [3:0] {
    CC_BEQ  = 4'd0,
    CC_BNE  = 4'd1,
    CC_BGT  = 4'd2,
    CC_BLT  = 4'd3,
    CC_BGE  = 4'd4,
    CC_BLE  = 4'd5,
    CC_BOF  = 4'd6,
    CC_TRUE = 4'd7
  } cond_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  function automatic logic cond_met(input logic [3:0] cond, input logic [2:0] flag);
    logic z, v, n, res;
    z = flag[FLAG_Z];
    v = flag[FLAG_V];
    n = flag[FLAG_N];
    case (cond)
      CC_BEQ:  res = z;
      CC_BNE:  res = ~z;
      CC_BGT:  res = ~z & ~n;
      CC_BLT:  res = n;
      CC_BGE:  res = z | (~z & ~n);
      CC_BLE:  res = z | n;
      CC_BOF:  res = v;
      CC_TRUE: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_instr_decode.sv
`default_nettype none
// pipe_instr_decode: combinational register-usage decode of one instruction.
// Rev 1.0
module pipe_instr_decode
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int IW       = 16,
  parameter int LINK_REG = 15
) (
  input  logic [IW-1:0] instr,
  output logic          is_writer,
  output logic [3:0]    dest,
  output logic [3:0]    src_a,
  output logic          use_a,
  output logic [3:0]    src_b,
  output logic          use_b,
  output logic          is_branch,
  output logic          is_jump,
  output logic          is_load
);

  logic [3:0] op;
  logic [3:0] rd, rs, rt;

  assign op = instr[IW-1:IW-4];
  assign rd = instr[11:8];
  assign rs = instr[7:4];
  assign rt = instr[3:0];

  always_comb begin
    is_writer = 1'b0;
    dest      = rd;
    src_a     = rs;
    use_a     = 1'b0;
    src_b     = rt;
    use_b     = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_load   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        is_writer = 1'b1;
        use_a     = 1'b1;
        use_b     = 1'b1;
      end
      OP_SLL, OP_SRL, OP_SRA, OP_RL: begin
        is_writer = 1'b1;
        use_a     = 1'b1;
      end
      OP_LW: begin
        is_writer = 1'b1;
        use_a     = 1'b1;
        is_load   = 1'b1;
      end
      // Stores read the data register through the rd field
      OP_SW: begin
        use_a = 1'b1;
        src_b = rd;
        use_b = 1'b1;
      end
      OP_LHB: begin
        is_writer = 1'b1;
        src_a     = rd;
        use_a     = 1'b1;
      end
      OP_LLB:  is_writer = 1'b1;
      OP_B:    is_branch = 1'b1;
      OP_JAL: begin
        is_writer = 1'b1;
        dest      = 4'(LINK_REG);
        is_jump   = 1'b1;
      end
      OP_JR: begin
        use_a   = 1'b1;
        is_jump = 1'b1;
      end
      OP_EXEC: use_a = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// pipe_hazard_ctrl: RAW stall detection, branch resolution and wrong-path flush beside the ID stage.
// Rev 1.0
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int IW          = 16,
  parameter int DEPTH       = 4,
  parameter int HAZ_WINDOW  = 3,
  parameter int FWD_EN      = 0,
  parameter int FLUSH_SLOTS = 2,
  parameter int LINK_REG    = 15,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr_in,
  input  logic          instr_valid,
  input  logic [2:0]    flag,
  output logic          stall,
  output logic          flush,
  output logic          br_taken,
  output logic          jump,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  // With forwarding only the load in hist[1] can cause a stall
  localparam int NCHK = (FWD_EN != 0) ? 1 : HAZ_WINDOW;

  logic          hist_valid [1:DEPTH];
  logic [IW-1:0] hist_instr [1:DEPTH];
  logic [2:0]    flush_cnt;

  logic       id_writer, id_branch, id_jump, id_load;
  logic [3:0] id_dest, id_src_a, id_src_b;
  logic       id_use_a, id_use_b;

  logic       chk_writer [1:NCHK];
  logic [3:0] chk_dest   [1:NCHK];
  logic       chk_branch [1:NCHK];
  logic       chk_jump   [1:NCHK];
  logic       chk_load   [1:NCHK];

  logic hazard;
  logic redirect;

  pipe_instr_decode #(.IW(IW), .LINK_REG(LINK_REG)) u_id_dec (
    .instr     (instr_in),
    .is_writer (id_writer),
    .dest      (id_dest),
    .src_a     (id_src_a),
    .use_a     (id_use_a),
    .src_b     (id_src_b),
    .use_b     (id_use_b),
    .is_branch (id_branch),
    .is_jump   (id_jump),
    .is_load   (id_load)
  );

  generate
    for (genvar k = 1; k <= NCHK; k++) begin : g_hist_dec
      logic [3:0] src_a, src_b;
      logic       use_a, use_b;
      logic       unused_src;

      pipe_instr_decode #(.IW(IW), .LINK_REG(LINK_REG)) u_dec (
        .instr     (hist_instr[k]),
        .is_writer (chk_writer[k]),
        .dest      (chk_dest[k]),
        .src_a     (src_a),
        .use_a     (use_a),
        .src_b     (src_b),
        .use_b     (use_b),
        .is_branch (chk_branch[k]),
        .is_jump   (chk_jump[k]),
        .is_load   (chk_load[k])
      );

      assign unused_src = ^{src_a, src_b, use_a, use_b};
    end
  endgenerate

  logic unused_misc;
  assign unused_misc = ^{id_writer, id_dest, id_branch, id_jump, id_load,
                         hist_valid[DEPTH], hist_instr[DEPTH]};

  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k <= NCHK; k++) begin
      if (instr_valid && hist_valid[k] && chk_writer[k] && (chk_dest[k] != 4'd0)
          && ((FWD_EN == 0) || chk_load[k])) begin
        if ((id_use_a && (id_src_a == chk_dest[k])) ||
            (id_use_b && (id_src_b == chk_dest[k]))) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign br_taken = ~rst & hist_valid[1] & chk_branch[1] & cond_met(hist_instr[1][11:8], flag);
  assign jump     = ~rst & hist_valid[1] & chk_jump[1];
  assign redirect = br_taken | jump;
  assign flush    = ~rst & (redirect | (flush_cnt != 3'd0));
  assign stall    = ~rst & ~flush & hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        hist_valid[k] <= 1'b0;
        hist_instr[k] <= '0;
      end
      flush_cnt   <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      // Squashed and stalled slots enter as invalid so they never retrigger anything
      hist_valid[1] <= instr_valid & ~flush & ~stall;
      hist_instr[1] <= stall ? '0 : instr_in;
      for (int k = 2; k <= DEPTH; k++) begin
        hist_valid[k] <= hist_valid[k-1];
        hist_instr[k] <= hist_instr[k-1];
      end

      if (redirect) begin
        flush_cnt <= 3'(FLUSH_SLOTS - 1);
      end else if (flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end

      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CW'(1);
      end
      if (flush && (flush_count != '1)) begin
        flush_count <= flush_count + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// tb_pipe_hazard_ctrl: directed and random checks of two controllers (no forwarding / forwarding).
// Rev 1.0
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic [2:0]  flag;

  logic        stall_o [2];
  logic        flush_o [2];
  logic        bt_o    [2];
  logic        jp_o    [2];
  logic [15:0] sc_o    [2];
  logic [15:0] fc_o    [2];

  // Observations captured in the last checked cycle
  logic        smp_st [2];
  logic        smp_fl [2];
  logic        smp_bt [2];
  logic        smp_jp [2];
  logic [15:0] smp_sc [2];
  logic [15:0] smp_fc [2];

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 is the youngest history entry
  bit          mv [2][4];
  logic [15:0] mi [2][4];
  int          mfleft [2];
  int          mscnt  [2];
  int          mfcnt  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(0)) dut0 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid), .flag(flag),
    .stall(stall_o[0]), .flush(flush_o[0]), .br_taken(bt_o[0]), .jump(jp_o[0]),
    .stall_count(sc_o[0]), .flush_count(fc_o[0])
  );

  pipe_hazard_ctrl #(.FWD_EN(1)) dut1 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid), .flag(flag),
    .stall(stall_o[1]), .flush(flush_o[1]), .br_taken(bt_o[1]), .jump(jp_o[1]),
    .stall_count(sc_o[1]), .flush_count(fc_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Destination register written, or -1 when the instruction writes nothing
  function automatic int m_dest(input logic [15:0] i);
    int op;
    op = int'(i[15:12]);
    if (op <= 8 || op == 10 || op == 11) return int'(i[11:8]);
    if (op == 13) return 15;
    return -1;
  endfunction

  function automatic bit m_reads(input logic [15:0] i, input int r);
    int op, rd, rs, rt;
    op = int'(i[15:12]);
    rd = int'(i[11:8]);
    rs = int'(i[7:4]);
    rt = int'(i[3:0]);
    if (r == 0) return 1'b0;
    if (op <= 3) return (rs == r) || (rt == r);
    if ((op >= 4 && op <= 8) || op == 14 || op == 15) return rs == r;
    if (op == 9) return (rs == r) || (rd == r);
    if (op == 10) return rd == r;
    return 1'b0;
  endfunction

  function automatic bit m_cond(input logic [3:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (int'(c))
      0: return z;
      1: return !z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return z || n;
      6: return v;
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_eval(input int m, input bit r,
                            output bit st, output bit fl, output bit bt, output bit jp);
    bit hz;
    int d;
    st = 0; fl = 0; bt = 0; jp = 0; hz = 0;
    if (!r) begin
      bt = mv[m][0] && (mi[m][0][15:12] == 4'd12) && m_cond(mi[m][0][11:8], flag);
      jp = mv[m][0] && ((mi[m][0][15:12] == 4'd13) || (mi[m][0][15:12] == 4'd14));
      fl = bt || jp || (mfleft[m] > 0);
      for (int k = 0; k < 3; k++) begin
        if (m == 0 || (k == 0 && mi[m][0][15:12] == 4'd8)) begin
          d = m_dest(mi[m][k]);
          if (mv[m][k] && instr_valid && d > 0 && m_reads(instr_in, d)) hz = 1;
        end
      end
      st = hz && !fl;
    end
  endtask

  task automatic model_update(input int m, input bit r, input logic [15:0] ins, input bit vld,
                              input bit st, input bit fl, input bit bt, input bit jp);
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        mv[m][k] = 0;
        mi[m][k] = '0;
      end
      mfleft[m] = 0;
      mscnt[m]  = 0;
      mfcnt[m]  = 0;
    end else begin
      for (int k = 3; k > 0; k--) begin
        mv[m][k] = mv[m][k-1];
        mi[m][k] = mi[m][k-1];
      end
      mv[m][0] = vld && !fl && !st;
      mi[m][0] = ins;
      if (bt || jp) mfleft[m] = 1;
      else if (mfleft[m] > 0) mfleft[m] = mfleft[m] - 1;
      if (st && mscnt[m] < 65535) mscnt[m] = mscnt[m] + 1;
      if (fl && mfcnt[m] < 65535) mfcnt[m] = mfcnt[m] + 1;
    end
  endtask

  task automatic do_cycle(input logic [15:0] ins, input bit vld, input logic [2:0] flg, input bit r);
    bit est [2];
    bit efl [2];
    bit ebt [2];
    bit ejp [2];
    @(negedge clk);
    rst         = r;
    instr_in    = ins;
    instr_valid = vld;
    flag        = flg;
    #1;
    for (int m = 0; m < 2; m++) begin
      model_eval(m, r, est[m], efl[m], ebt[m], ejp[m]);
      smp_st[m] = stall_o[m];
      smp_fl[m] = flush_o[m];
      smp_bt[m] = bt_o[m];
      smp_jp[m] = jp_o[m];
      smp_sc[m] = sc_o[m];
      smp_fc[m] = fc_o[m];
      chk($sformatf("m%0d_stall", m), 32'(smp_st[m]), 32'(est[m]));
      chk($sformatf("m%0d_flush", m), 32'(smp_fl[m]), 32'(efl[m]));
      chk($sformatf("m%0d_br_taken", m), 32'(smp_bt[m]), 32'(ebt[m]));
      chk($sformatf("m%0d_jump", m), 32'(smp_jp[m]), 32'(ejp[m]));
      chk($sformatf("m%0d_stall_count", m), 32'(smp_sc[m]), 32'(mscnt[m]));
      chk($sformatf("m%0d_flush_count", m), 32'(smp_fc[m]), 32'(mfcnt[m]));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_update(m, r, ins, vld, est[m], efl[m], ebt[m], ejp[m]);
  endtask

  task automatic reset2();
    do_cycle(16'h0123, 1'b1, 3'b000, 1'b1);
    do_cycle(16'h0123, 1'b1, 3'b000, 1'b1);
  endtask

  initial begin
    logic [15:0] ri;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        mv[m][k] = 0;
        mi[m][k] = '0;
      end
      mfleft[m] = 0;
      mscnt[m]  = 0;
      mfcnt[m]  = 0;
    end
    rst = 1'b1; instr_in = 16'h0123; instr_valid = 1'b1; flag = 3'b000;
    @(posedge clk);

    // Reset behaviour
    reset2();
    chk("rst_stall", 32'(smp_st[0]), 32'd0);
    chk("rst_flush", 32'(smp_fl[0]), 32'd0);
    chk("rst_stall_count", 32'(smp_sc[0]), 32'd0);
    chk("rst_flush_count", 32'(smp_fc[0]), 32'd0);
    do_cycle(16'h0123, 1'b1, 3'b000, 1'b0);
    chk("post_rst_no_stall", 32'(smp_st[0]), 32'd0);

    // ADD R1 then SUB reading R1: three stall cycles without forwarding, none with it
    for (int i = 0; i < 4; i++) begin
      do_cycle(16'h1415, 1'b1, 3'b000, 1'b0);
      chk($sformatf("raw_stall_c%0d", i), 32'(smp_st[0]), (i < 3) ? 32'd1 : 32'd0);
      chk($sformatf("fwd_add_nostall_c%0d", i), 32'(smp_st[1]), 32'd0);
    end
    do_cycle(16'h0000, 1'b0, 3'b000, 1'b0);
    chk("raw_stall_count", 32'(smp_sc[0]), 32'd3);
    chk("fwd_stall_count_zero", 32'(smp_sc[1]), 32'd0);

    // Load-use with forwarding: one stall cycle
    reset2();
    do_cycle(16'h8120, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(16'h0415, 1'b1, 3'b000, 1'b0);
      chk($sformatf("lw_use_fwd_c%0d", i), 32'(smp_st[1]), (i == 0) ? 32'd1 : 32'd0);
      chk($sformatf("lw_use_nofwd_c%0d", i), 32'(smp_st[0]), (i < 3) ? 32'd1 : 32'd0);
    end
    do_cycle(16'h0000, 1'b0, 3'b000, 1'b0);
    chk("lw_use_fwd_count", 32'(smp_sc[1]), 32'd1);

    // Taken BEQ flushes two slots; squashed ADD R1 must not make the SUB stall
    reset2();
    do_cycle(16'hC012, 1'b1, 3'b100, 1'b0);
    do_cycle(16'h0123, 1'b1, 3'b100, 1'b0);
    chk("beq_taken", 32'(smp_bt[0]), 32'd1);
    chk("beq_flush1", 32'(smp_fl[0]), 32'd1);
    do_cycle(16'h1415, 1'b1, 3'b100, 1'b0);
    chk("beq_flush2", 32'(smp_fl[0]), 32'd1);
    do_cycle(16'h1415, 1'b1, 3'b100, 1'b0);
    chk("beq_flush_end", 32'(smp_fl[0]), 32'd0);
    chk("beq_squashed_no_stall", 32'(smp_st[0]), 32'd0);
    do_cycle(16'h0000, 1'b0, 3'b100, 1'b0);
    chk("beq_flush_count", 32'(smp_fc[0]), 32'd2);
    do_cycle(16'hC112, 1'b1, 3'b100, 1'b0);
    do_cycle(16'h0000, 1'b0, 3'b100, 1'b0);
    chk("bne_not_taken", 32'(smp_bt[0]), 32'd0);
    chk("bne_no_flush", 32'(smp_fl[0]), 32'd0);

    // JAL followed by a reader of the link register
    reset2();
    do_cycle(16'hD000, 1'b1, 3'b000, 1'b0);
    do_cycle(16'h02F0, 1'b1, 3'b000, 1'b0);
    chk("jal_jump", 32'(smp_jp[0]), 32'd1);
    chk("jal_flush", 32'(smp_fl[0]), 32'd1);
    chk("jal_flush_beats_stall", 32'(smp_st[0]), 32'd0);
    do_cycle(16'h0425, 1'b1, 3'b000, 1'b0);
    do_cycle(16'h0425, 1'b1, 3'b000, 1'b0);
    chk("jal_squashed_no_stall", 32'(smp_st[0]), 32'd0);
    chk("jal_flush_done", 32'(smp_fl[0]), 32'd0);

    // R0 destination never stalls
    reset2();
    do_cycle(16'h0023, 1'b1, 3'b000, 1'b0);
    do_cycle(16'h0405, 1'b1, 3'b000, 1'b0);
    chk("r0_no_stall", 32'(smp_st[0]), 32'd0);

    // Reset in the second flush cycle ends the flush
    reset2();
    do_cycle(16'hC700, 1'b1, 3'b000, 1'b0);
    do_cycle(16'h0000, 1'b0, 3'b000, 1'b0);
    chk("true_flush1", 32'(smp_fl[0]), 32'd1);
    do_cycle(16'h0000, 1'b0, 3'b000, 1'b1);
    chk("rst_mid_flush_out", 32'(smp_fl[0]), 32'd0);
    do_cycle(16'h0000, 1'b0, 3'b000, 1'b0);
    chk("rst_mid_flush_after", 32'(smp_fl[0]), 32'd0);
    chk("rst_mid_flush_count", 32'(smp_fc[0]), 32'd0);

    // Random traffic over a small register set so hazards are frequent
    reset2();
    for (int i = 0; i < 400; i++) begin
      ri = 16'($urandom);
      if ($urandom_range(0, 2) != 0) ri[11:0] = {2'b00, ri[9:8], 2'b00, ri[5:4], 2'b00, ri[1:0]};
      do_cycle(ri, ($urandom_range(0, 3) != 0), 3'($urandom), ($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
